// File: rtl/alu_seriale_seq.sv
// alu_seriale_seq -- bit-serial ALU sequencer for the 16-bit CPU.
//
// Feeds an external 5-to-1 one-bit result mux with one operand bit per
// clock and shifts the selected bit (Dalja) back into the result register.
// A full-width result is available WIDTH cycles after Start is accepted.
//
// Ports:
//   Clock            rising-edge clock
//   Reset            asynchronous, active-high reset
//   Start            request; sampled only in IDLE or DONE
//   A, B [WIDTH]     operands, latched on an accepted Start
//   Op [3]           000 AND, 001 OR, 010 ADD, 011 SUB, 1xx XOR
//   Hyrja0..Hyrja4   per-bit mux candidates: AND, OR, ADD-sum, SUB-diff, XOR
//   S [3]            mux select (latched Op)
//   Dalja            selected bit returned from the mux
//   Result [WIDTH]   final result (partial shift contents while Busy)
//   Zero, Carry      flags (Carry: ADD carry-out, SUB no-borrow, 0 otherwise)
//   Busy             high in RUN
//   Done             high for the cycle in DONE
//   state_dbg [2]    current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: Start is a request that is accepted on any rising edge where
// the sequencer is in IDLE or DONE; Busy then rises for exactly WIDTH
// cycles, followed by one Done cycle. Start in RUN is ignored.
//
// Configuration macro: SERIAL_ALU_FLAGS_EN. When undefined, Zero and Carry
// are tied to 0 and no flag registers exist; result and timing are the same.

module alu_seriale_seq #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  output logic             Hyrja0,
  output logic             Hyrja1,
  output logic             Hyrja2,
  output logic             Hyrja3,
  output logic             Hyrja4,
  output logic [2:0]       S,
  input  logic             Dalja,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Carry,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    cnt;
  logic             cadd;
  logic             csub;

  logic             a_bit;
  logic             b_bit;
  logic             run;
  logic             last;
  logic             maj_add;
  logic             maj_sub;
  logic [WIDTH-1:0] res_next;

  assign a_bit   = a_reg[0];
  assign b_bit   = b_reg[0];
  assign run     = (state == RUN);
  assign last    = run && (cnt == LAST);
  assign maj_add = (a_bit & b_bit) | (a_bit & cadd) | (b_bit & cadd);
  assign maj_sub = (a_bit & ~b_bit) | (a_bit & csub) | (~b_bit & csub);
  // Result fills from the MSB so that bit 0 lands in Result[0] after WIDTH shifts.
  assign res_next = {Dalja, Result[WIDTH-1:1]};

  // Candidates are forced low outside RUN so the mux sees a quiet bus.
  assign Hyrja0 = run & (a_bit & b_bit);
  assign Hyrja1 = run & (a_bit | b_bit);
  assign Hyrja2 = run & (a_bit ^ b_bit ^ cadd);
  assign Hyrja3 = run & (a_bit ^ ~b_bit ^ csub);
  assign Hyrja4 = run & (a_bit ^ b_bit);

  assign state_dbg = state;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      cnt    <= '0;
      cadd   <= 1'b0;
      csub   <= 1'b1;
      S      <= 3'b000;
      Result <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            a_reg <= A;
            b_reg <= B;
            S     <= Op;
            cnt   <= '0;
            cadd  <= 1'b0;
            csub  <= 1'b1;
            state <= RUN;
            Busy  <= 1'b1;
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
          Done <= 1'b0;
        end
        RUN: begin
          Result <= res_next;
          cadd   <= maj_add;
          csub   <= maj_sub;
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            cnt   <= '0;
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  // Flags come from the last-bit carry (not yet registered) and the
  // result value that includes the bit being shifted in on this edge.
  logic carry_next;

  always_comb begin
    carry_next = 1'b0;
    if (S == 3'b010) carry_next = maj_add;
    else if (S == 3'b011) carry_next = maj_sub;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Zero  <= 1'b0;
      Carry <= 1'b0;
    end else if (last) begin
      Zero  <= (res_next == '0);
      Carry <= carry_next;
    end
  end
`else
  assign Zero  = 1'b0;
  assign Carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seriale_seq.sv
// Self-checking bench for alu_seriale_seq: directed vectors with
// hand-computed results, an external 5-to-1 mux model, latency and
// handshake checks, Start-ignored-in-RUN, mid-RUN reset and chaining.

module tb_alu_seriale_seq;

  localparam int W = 16;

  logic         Clock;
  logic         Reset;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   Op;
  logic         Hyrja0, Hyrja1, Hyrja2, Hyrja3, Hyrja4;
  logic [2:0]   S;
  logic         Dalja;
  logic [W-1:0] Result;
  logic         Zero;
  logic         Carry;
  logic         Busy;
  logic         Done;
  logic [1:0]   state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  alu_seriale_seq #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .A(A), .B(B), .Op(Op),
    .Hyrja0(Hyrja0), .Hyrja1(Hyrja1), .Hyrja2(Hyrja2),
    .Hyrja3(Hyrja3), .Hyrja4(Hyrja4),
    .S(S), .Dalja(Dalja),
    .Result(Result), .Zero(Zero), .Carry(Carry),
    .Busy(Busy), .Done(Done), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // The external 5-to-1 result mux the sequencer drives.
  always_comb begin
    case (S)
      3'b000:  Dalja = Hyrja0;
      3'b001:  Dalja = Hyrja1;
      3'b010:  Dalja = Hyrja2;
      3'b011:  Dalja = Hyrja3;
      default: Dalja = Hyrja4;
    endcase
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flags only exist when the feature macro is on.
  function automatic logic flag(input logic v);
`ifdef SERIAL_ALU_FLAGS_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- drivers ----------------
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    @(negedge Clock);
    A = a; B = b; Op = op; Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
  endtask

  // Counts rising edges until Done is seen; a result of 40 means timeout.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge Clock);
      #1;
      n++;
      if (Done) break;
    end
  endtask

  task automatic check_result(input string tag, input logic z, input logic c);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check({tag, "_result"}, 32'(Result), 32'(e));
    check({tag, "_zero"}, 32'(Zero), 32'(flag(z)));
    check({tag, "_carry"}, 32'(Carry), 32'(flag(c)));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [W-1:0] r,
                        input logic z, input logic c);
    int n;
    exp_q.push_back(r);
    start_op(a, b, op);
    check({tag, "_busy"}, 32'(Busy), 32'd1);
    wait_done(n);
    check({tag, "_latency"}, 32'(n), 32'd16);
    check_result(tag, z, c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  n;
    logic seen;
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0; Op = 3'b000;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("rst_result", 32'(Result), 32'h0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // ADD with explicit first-bit candidate check.
    exp_q.push_back(16'h2233);
    start_op(16'h1234, 16'h0FFF, 3'b010);
    check("add1_sel", 32'(S), 32'h2);
    check("add1_hyrja_bit0", 32'({Hyrja4, Hyrja3, Hyrja2, Hyrja1, Hyrja0}), 32'b11110);
    check("add1_state", 32'(state_dbg), 32'd1);
    wait_done(n);
    check("add1_latency", 32'(n), 32'd16);
    check_result("add1", 1'b0, 1'b0);
    check("add1_hyrja_idle", 32'({Hyrja4, Hyrja3, Hyrja2, Hyrja1, Hyrja0}), 32'h0);
    @(posedge Clock); #1;
    check("add1_done_one_cycle", 32'(Done), 32'd0);
    check("add1_result_hold", 32'(Result), 32'h2233);

    run_op("add_wrap", 16'hFFFF, 16'h0001, 3'b010, 16'h0000, 1'b1, 1'b1);
    run_op("sub_eq",   16'h0005, 16'h0005, 3'b011, 16'h0000, 1'b1, 1'b1);
    run_op("sub_neg",  16'h0005, 16'h0007, 3'b011, 16'hFFFE, 1'b0, 1'b0);
    run_op("xor",      16'hAAAA, 16'hFFFF, 3'b100, 16'h5555, 1'b0, 1'b0);

    // AND with a Start pulse in RUN cycle 5 that must be ignored.
    exp_q.push_back(16'h3030);
    start_op(16'hF0F0, 16'h3C3C, 3'b000);
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    A = 16'hFFFF; B = 16'hFFFF; Op = 3'b001; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    check("ign_busy", 32'(Busy), 32'd1);
    wait_done(n);
    check("ign_latency", 32'(n), 32'd11);
    check_result("ign", 1'b0, 1'b0);
    check("ign_sel", 32'(S), 32'h0);

    // Reset in the middle of an ADD.
    start_op(16'h1234, 16'h0FFF, 3'b010);
    repeat (7) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("mid_rst_result", 32'(Result), 32'h0);
    check("mid_rst_sel", 32'(S), 32'h0);
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_done", 32'(Done), 32'd0);
    check("mid_rst_flags", 32'({Zero, Carry}), 32'h0);
    check("mid_rst_hyrja", 32'({Hyrja4, Hyrja3, Hyrja2, Hyrja1, Hyrja0}), 32'h0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock); #1;
      if (Done) seen = 1'b1;
    end
    check("mid_rst_no_done", 32'(seen), 32'd0);

    run_op("or", 16'h00FF, 16'h0F00, 3'b001, 16'h0FFF, 1'b0, 1'b0);

    // Chaining: Start held high while in DONE.
    exp_q.push_back(16'h0000);
    start_op(16'h0005, 16'h0005, 3'b011);
    wait_done(n);
    check("chain1_latency", 32'(n), 32'd16);
    A = 16'h0001; B = 16'h0001; Op = 3'b010; Start = 1'b1;
    check_result("chain1", 1'b1, 1'b1);
    @(posedge Clock); #1;
    Start = 1'b0;
    check("chain2_busy", 32'(Busy), 32'd1);
    check("chain2_done_low", 32'(Done), 32'd0);
    exp_q.push_back(16'h0002);
    wait_done(n);
    check("chain2_latency", 32'(n), 32'd16);
    check_result("chain2", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seriale_seq.md
# alu_seriale_seq

- Bit-serial ALU sequencer for the 16-bit CPU.
- Sits around the 5-to-1 one-bit result mux.
  - Upstream: drives the mux's five candidate bits and its 3-bit select, one operand bit per clock.
  - Downstream: captures the mux output bit back into a result shift register.
- Produces the full-width result plus Zero/Carry flags after WIDTH cycles, with a Start/Busy/Done handshake toward the control unit.

## Interface
- WIDTH, 16, operand/result width in bits (≥2).
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request; sampled only in IDLE or DONE.
- A  in  WIDTH  operand A; latched on accepted Start.
- B  in  WIDTH  operand B; latched on accepted Start.
- Op  in  3  operation: 000 AND, 001 OR, 010 ADD, 011 SUB, 1xx XOR; latched on accepted Start.
- Hyrja0..Hyrja4  out  1 each  per-bit candidates to the mux: AND, OR, ADD-sum, SUB-diff, XOR.
- S  out  3  mux select; equals latched Op.
- Dalja  in  1  selected bit returned from the mux.
- Result  out  WIDTH  final result.
- Zero  out  1  Result == 0.
- Carry  out  1  ADD carry-out; SUB no-borrow (1 = A≥B unsigned); 0 for logic ops.
- Busy  out  1  high in RUN.
- Done  out  1  high in DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, Start=1: latch A, B, Op into shift registers; set bit counter=0, add-carry=0, sub-carry=1; go to RUN.
- RUN, each cycle:
  - Current bits a=Areg[0], b=Breg[0].
  - Hyrja0=a&b, Hyrja1=a|b, Hyrja2=a^b^cadd, Hyrja3=a^~b^csub, Hyrja4=a^b.
  - On the edge:
    - Shift Dalja into Result MSB, Result shifts right.
    - Update cadd=maj(a,b,cadd) and csub=maj(a,~b,csub).
    - Shift Areg/Breg right.
    - Increment counter.
- RUN, counter==WIDTH-1: on that edge also load flags (Zero from the final Result value including this bit; Carry per Op) and go to DONE.
- DONE: Done=1. Start=1 → behaves as IDLE+Start (new op, next state RUN). Start=0 → IDLE.
- Start is ignored in RUN; the operands and Op in flight are unaffected.
- Result, Zero and Carry hold their values from DONE until the next op's last RUN edge.
  - During RUN, Result shows partial shift contents and must not be consumed.
- Outside RUN: Hyrja0..4 = 0 and S holds its last value.
- Arithmetic is modulo 2^WIDTH. SUB is computed as A + ~B + 1.
- Reset, any state including mid-RUN:
  - State=IDLE.
  - Result=0, Zero=0, Carry=0, S=000.
  - Busy=0, Done=0, Hyrja0..4=0.
  - Counter, operand registers and carries cleared; sub-carry reset value 1.
  - An aborted op produces no Done.

## Timing
- Latency: Start accepted at edge 0; RUN covers WIDTH cycles; Done is high for the cycle following edge WIDTH (16 → cycle 17), for exactly one cycle unless chained.
- Back-to-back: Start held high through DONE → Busy rises the next cycle. Throughput is one op per WIDTH+1 cycles.
- The mux path is combinational: Hyrja*/S → Dalja must settle within one clock period. Dalja is sampled only on RUN edges.

## Configuration
- SERIAL_ALU_FLAGS_EN defined: Zero/Carry registers and carry chains drive flags as specified.
- SERIAL_ALU_FLAGS_EN undefined:
  - Zero and Carry are tied 0 and the flag registers are omitted.
  - Result, Done and latency are unchanged.

## Test plan
- ADD, A=0x1234, B=0x0FFF, Op=010 → Done at cycle 17, Result=0x2233, Carry=0, Zero=0.
- ADD, A=0xFFFF, B=0x0001 → Result=0x0000, Carry=1, Zero=1. SUB, A=0x0005, B=0x0005 → Result=0x0000, Carry=1, Zero=1.
- SUB, A=0x0005, B=0x0007, Op=011 → Result=0xFFFE, Carry=0. XOR, A=0xAAAA, B=0xFFFF, Op=100 → Result=0x5555, Carry=0.
- AND, A=0xF0F0, B=0x3C3C → Result=0x3030. Start pulsed at RUN cycle 5 with different operands → ignored, Result still 0x3030.
- Reset asserted at RUN cycle 8 of an ADD → all outputs immediately 0, no Done pulse. Then OR, A=0x00FF, B=0x0F00 → Result=0x0FFF.
- Start held high across DONE → second op (ADD 0x0001+0x0001) begins the cycle after Done, giving Result=0x0002 with Done 17 cycles later. With the macro undefined, Zero=Carry=0 for all of the above.
